// File: rtl/tmp_code_acc_if.sv
// Handshake bundle between the temperature controller, tmp_code_acc and readout.
// master: controller/readout side; slave: the accumulator.
interface tmp_code_acc_if #(
    parameter int CNT_W = 10
);
    logic                    conv_start;
    logic                    conv_end;
    logic                    snk_evt;
    logic                    src_evt;
    logic                    out_ready;
    logic                    err_clr;
    logic                    out_valid;
    logic signed [CNT_W:0]   out_code;
    logic                    busy;
    logic                    overrun;
    logic                    timeout_err;

    modport master (
        output conv_start, conv_end, snk_evt, src_evt,
        output out_ready, err_clr,
        input  out_valid, out_code, busy, overrun, timeout_err
    );

    modport slave (
        input  conv_start, conv_end, snk_evt, src_evt,
        input  out_ready, err_clr,
        output out_valid, out_code, busy, overrun, timeout_err
    );
endinterface

// File: rtl/tmp_code_acc.sv
// Net-charge code accumulator: counts sink/source events per window,
// averages 2**AVG_LOG2 windows and offers the code on a valid/ready port.
// Ports: clk, reset_n (async, active-low), bus (tmp_code_acc_if.slave):
//   in  conv_start/conv_end/snk_evt/src_evt/out_ready/err_clr
//   out out_valid/out_code/busy/overrun/timeout_err
module tmp_code_acc #(
    parameter int CNT_W    = 10,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic          clk,
    input  logic          reset_n,
    tmp_code_acc_if.slave bus
);
    localparam int SUM_W = CNT_W + 1 + AVG_LOG2;
    localparam int WIN_W = $clog2(TIMEOUT + 1);
    localparam int NC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(TIMEOUT);
    localparam logic [NC_W-1:0]  NC_LAST  = NC_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_REDUCE,
        S_OUTPUT
    } state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          snk_q, snk_d;
    logic [CNT_W-1:0]          src_q, src_d;
    logic [WIN_W-1:0]          win_q, win_d;
    logic signed [SUM_W-1:0]   sum_q, sum_d;
    logic [NC_W-1:0]           nconv_q, nconv_d;
    logic signed [CNT_W:0]     out_code_q, out_code_d;
    logic                      out_valid_q, out_valid_d;
    logic                      busy_q, busy_d;
    logic                      ovr_q, ovr_d;
    logic                      to_q, to_d;

    logic                      ovr_set;
    logic                      to_set;
    logic signed [CNT_W:0]     diff;
    logic signed [SUM_W-1:0]   sum_nxt;
    logic signed [SUM_W-1:0]   avg;

    always_comb begin
        state_d    = state_q;
        snk_d      = snk_q;
        src_d      = src_q;
        win_d      = win_q;
        sum_d      = sum_q;
        nconv_d    = nconv_q;
        out_code_d = out_code_q;
        ovr_set    = 1'b0;
        to_set     = 1'b0;

        diff    = $signed({1'b0, snk_q}) - $signed({1'b0, src_q});
        sum_nxt = sum_q + SUM_W'(diff);
        // arithmetic shift: average rounds toward -inf
        avg     = sum_nxt >>> AVG_LOG2;

        unique case (state_q)
            S_IDLE: begin
                if (bus.conv_start) begin
                    state_d = S_ACCUM;
                    snk_d   = '0;
                    src_d   = '0;
                    win_d   = '0;
                end
            end
            S_ACCUM: begin
                win_d = win_q + WIN_W'(1);
                if (bus.snk_evt && snk_q != CNT_MAX)
                    snk_d = snk_q + CNT_W'(1);
                if (bus.src_evt && src_q != CNT_MAX)
                    src_d = src_q + CNT_W'(1);
                // restart beats close; close beats timeout
                if (bus.conv_start) begin
                    snk_d = '0;
                    src_d = '0;
                    win_d = '0;
                end else if (bus.conv_end) begin
                    state_d = S_REDUCE;
                end else if (win_q == WIN_LAST) begin
                    to_set  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_REDUCE: begin
                if (nconv_q == NC_LAST) begin
                    out_code_d = avg[CNT_W:0];
                    sum_d      = '0;
                    nconv_d    = '0;
                    state_d    = S_OUTPUT;
                end else begin
                    sum_d   = sum_nxt;
                    nconv_d = nconv_q + NC_W'(1);
                    state_d = S_IDLE;
                end
            end
            S_OUTPUT: begin
                if (bus.conv_start)
                    ovr_set = 1'b1;
                if (bus.out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // sticky flags: a same-cycle set outranks the clear
        ovr_d       = ovr_set | (ovr_q & ~bus.err_clr);
        to_d        = to_set | (to_q & ~bus.err_clr);
        out_valid_d = (state_d == S_OUTPUT);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            snk_q       <= '0;
            src_q       <= '0;
            win_q       <= '0;
            sum_q       <= '0;
            nconv_q     <= '0;
            out_code_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovr_q       <= 1'b0;
            to_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            snk_q       <= snk_d;
            src_q       <= src_d;
            win_q       <= win_d;
            sum_q       <= sum_d;
            nconv_q     <= nconv_d;
            out_code_q  <= out_code_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            ovr_q       <= ovr_d;
            to_q        <= to_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_code    = out_code_q;
    assign bus.busy        = busy_q;
    assign bus.overrun     = ovr_q;
    assign bus.timeout_err = to_q;
endmodule

// File: tb/tb_tmp_code_acc.sv
// Directed bench for tmp_code_acc: u0 has no averaging (long timeout),
// u2 averages four windows; both see the same stimulus.
module tb_tmp_code_acc;
    localparam int CNT_W = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic conv_start = 1'b0;
    logic conv_end = 1'b0;
    logic snk_evt = 1'b0;
    logic src_evt = 1'b0;
    logic out_ready = 1'b0;
    logic err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tmp_code_acc_if #(.CNT_W(CNT_W)) if0 ();
    tmp_code_acc_if #(.CNT_W(CNT_W)) if2 ();

    assign if0.conv_start = conv_start;
    assign if0.conv_end   = conv_end;
    assign if0.snk_evt    = snk_evt;
    assign if0.src_evt    = src_evt;
    assign if0.out_ready  = out_ready;
    assign if0.err_clr    = err_clr;
    assign if2.conv_start = conv_start;
    assign if2.conv_end   = conv_end;
    assign if2.snk_evt    = snk_evt;
    assign if2.src_evt    = src_evt;
    assign if2.out_ready  = out_ready;
    assign if2.err_clr    = err_clr;

    tmp_code_acc #(
        .CNT_W(CNT_W), .AVG_LOG2(0), .TIMEOUT(2047)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .bus(if0.slave)
    );

    tmp_code_acc #(
        .CNT_W(CNT_W), .AVG_LOG2(2), .TIMEOUT(1023)
    ) u2 (
        .clk(clk), .reset_n(reset_n), .bus(if2.slave)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    // conv_start, then ns sink / nr source events (overlapping), conv_end;
    // returns in the REDUCE cycle
    task automatic window(input int ns, input int nr);
        int n;
        n = (ns > nr) ? ns : nr;
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            snk_evt = (i < ns);
            src_evt = (i < nr);
            tick();
        end
        snk_evt = 1'b0;
        src_evt = 1'b0;
        conv_end = 1'b1;
        tick();
        conv_end = 1'b0;
    endtask

    initial begin
        int n;

        // reset state
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst_valid", int'(if0.out_valid), 0);
        chk("rst_code", int'(if0.out_code), 0);
        chk("rst_busy", int'(if0.busy), 0);
        chk("rst_ovr", int'(if0.overrun), 0);
        chk("rst_to", int'(if0.timeout_err), 0);
        reset_n = 1'b1;
        tick();

        // single window, no averaging, latency t+2
        window(5, 2);
        chk("t1_valid_t1", int'(if0.out_valid), 0);
        chk("t1_busy", int'(if0.busy), 1);
        tick();
        chk("t1_valid_t2", int'(if0.out_valid), 1);
        chk("t1_code", int'(if0.out_code), 3);
        out_ready = 1'b1;
        tick();
        chk("t1_valid_xfer", int'(if0.out_valid), 0);
        chk("t1_code_hold", int'(if0.out_code), 3);
        out_ready = 1'b0;
        tick();

        // four-window average: 4+4+5-2 = 11 -> 2
        do_reset();
        out_ready = 1'b1;
        window(4, 0);
        tick();
        chk("t2_w1_valid", int'(if2.out_valid), 0);
        tick();
        window(4, 0);
        tick();
        chk("t2_w2_valid", int'(if2.out_valid), 0);
        tick();
        window(5, 0);
        tick();
        chk("t2_w3_valid", int'(if2.out_valid), 0);
        tick();
        window(0, 2);
        tick();
        chk("t2_valid", int'(if2.out_valid), 1);
        chk("t2_code", int'(if2.out_code), 2);
        tick();
        chk("t2_xfer", int'(if2.out_valid), 0);
        // -1-1-1-2 = -5 -> floor(-1.25) = -2
        for (int w = 0; w < 3; w++) begin
            window(0, 1);
            tick();
            tick();
        end
        window(0, 2);
        tick();
        chk("t2_neg_valid", int'(if2.out_valid), 1);
        chk("t2_neg_code", int'(if2.out_code), -2);
        tick();

        // simultaneous events, saturation, conv_end-cycle event, restart
        do_reset();
        out_ready = 1'b1;
        window(11, 8);
        tick();
        chk("t3_both_code", int'(if0.out_code), 3);
        tick();
        window(1100, 0);
        tick();
        chk("t3_sat_valid", int'(if0.out_valid), 1);
        chk("t3_sat_code", int'(if0.out_code), 1023);
        tick();
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
        snk_evt = 1'b1;
        tick();
        tick();
        conv_end = 1'b1;
        tick();
        conv_end = 1'b0;
        snk_evt = 1'b0;
        tick();
        chk("t3_end_evt", int'(if0.out_code), 3);
        tick();
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
        snk_evt = 1'b1;
        repeat (4) tick();
        snk_evt = 1'b0;
        conv_start = 1'b1;
        conv_end = 1'b1;
        tick();
        conv_start = 1'b0;
        conv_end = 1'b0;
        snk_evt = 1'b1;
        tick();
        snk_evt = 1'b0;
        conv_end = 1'b1;
        tick();
        conv_end = 1'b0;
        tick();
        chk("t3_restart", int'(if0.out_code), 1);
        tick();

        // window timeout on u2 (TIMEOUT=1023)
        do_reset();
        out_ready = 1'b0;
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
        n = 0;
        while (!if2.timeout_err && n < 1100) begin
            tick();
            n++;
        end
        chk("t4_seen", int'(if2.timeout_err), 1);
        chk("t4_lat", int'(n >= 1023 && n <= 1025), 1);
        chk("t4_busy", int'(if2.busy), 0);
        chk("t4_valid", int'(if2.out_valid), 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_clr", int'(if2.timeout_err), 0);

        // overrun while output stalled
        do_reset();
        out_ready = 1'b0;
        window(3, 1);
        tick();
        chk("t5_code", int'(if0.out_code), 2);
        conv_start = 1'b1;
        err_clr = 1'b1;
        tick();
        conv_start = 1'b0;
        err_clr = 1'b0;
        chk("t5_set_wins", int'(if0.overrun), 1);
        chk("t5_code_hold", int'(if0.out_code), 2);
        chk("t5_valid_hold", int'(if0.out_valid), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t5_clr", int'(if0.overrun), 0);
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
        chk("t5_ovr", int'(if0.overrun), 1);
        out_ready = 1'b1;
        tick();
        chk("t5_xfer", int'(if0.out_valid), 0);
        out_ready = 1'b0;
        tick();

        // async reset mid-ACCUM
        do_reset();
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
        snk_evt = 1'b1;
        repeat (3) tick();
        snk_evt = 1'b0;
        chk("t6_acc_busy_pre", int'(if0.busy), 1);
        reset_n = 1'b0;
        #1;
        chk("t6_acc_busy", int'(if0.busy), 0);
        chk("t6_acc_busy2", int'(if2.busy), 0);
        reset_n = 1'b1;
        tick();
        conv_end = 1'b1;
        tick();
        conv_end = 1'b0;
        tick();
        tick();
        chk("t6_idle_valid", int'(if0.out_valid), 0);
        chk("t6_idle_busy", int'(if0.busy), 0);

        // async reset mid-OUTPUT
        window(2, 0);
        tick();
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
        chk("t6_out_valid_pre", int'(if0.out_valid), 1);
        chk("t6_out_ovr_pre", int'(if0.overrun), 1);
        reset_n = 1'b0;
        #1;
        chk("t6_out_valid", int'(if0.out_valid), 0);
        chk("t6_out_code", int'(if0.out_code), 0);
        chk("t6_out_ovr", int'(if0.overrun), 0);
        chk("t6_out_busy", int'(if0.busy), 0);
        reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
